ctrl_multiciclo: RTL and testbench

Multicycle control FSM for the RV64 datapath: it sequences PC, instruction register, register file, A/B/ALUOUT/MDR registers, the ALU operand muxes and both memories, one instruction at a time. It decodes add, sub, addi, ld, sd, beq, bne, lui and break from the instruction-register fields. It drives every datapath load/write strobe and mux select. Unsupported encodings are flagged and skipped.

---
 rtl/ctrl_multiciclo.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_ctrl_multiciclo.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_multiciclo.sv
// -----------------------------------------------------------------------------
// ctrl_multiciclo
//
// Multicycle control unit for the RV64 datapath. It steps one instruction at a
// time through fetch, decode, execute, memory and write-back. Every datapath
// strobe and mux select is driven from here. Supported instructions are add,
// sub, addi, ld, sd, beq, bne, lui and break. Any other encoding raises
// ILLEGAL and is skipped by advancing the PC.
//
// Ports
//   CLK           in   system clock, rising edge
//   RESET         in   asynchronous, active-low reset
//   OPCODE[6:0]   in   IR[6:0]
//   FUNCT3[2:0]   in   IR[14:12]
//   FUNCT7[6:0]   in   IR[31:25]
//   IGUAL         in   ALU equality flag (A == B), combinational from the ALU
//   PC_WRITE .. MEM64_WR  out  one-cycle register/memory write strobes
//   PC_SRC        out  0: PC <= ALU result, 1: PC <= ALUOUT (branch target)
//   ALU_SRCA      out  0: PC, 1: A
//   ALU_SRCB[1:0] out  00: B, 01: 4, 10: imm, 11: imm << 1
//   ALU_SELECTOR  out  001 add, 010 sub, 111 compare, 000 idle
//   MEM_TO_REG    out  write-back source: 00 ALUOUT, 01 MDR, 10 imm
//   ILLEGAL       out  one-cycle pulse in DECODE on an unsupported encoding
//   HALTED        out  high while the machine is halted
//   STATE[3:0]    out  current state code, for debug
// -----------------------------------------------------------------------------
module ctrl_multiciclo (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNCT3,
  input  logic [6:0] FUNCT7,
  input  logic       IGUAL,
  output logic       PC_WRITE,
  output logic       IR_WRITE,
  output logic       LOAD_A,
  output logic       LOAD_B,
  output logic       LOAD_ALUOUT,
  output logic       LOAD_MDR,
  output logic       BANCO_WRITE,
  output logic       MEM64_WR,
  output logic       PC_SRC,
  output logic       ALU_SRCA,
  output logic [1:0] ALU_SRCB,
  output logic [2:0] ALU_SELECTOR,
  output logic [1:0] MEM_TO_REG,
  output logic       ILLEGAL,
  output logic       HALTED,
  output logic [3:0] STATE
);

  // State codes are visible on STATE, so the encoding is fixed.
  typedef enum logic [3:0] {
    S_RESET       = 4'd0,
    S_FETCH       = 4'd1,
    S_FETCH_WAIT  = 4'd2,
    S_DECODE      = 4'd3,
    S_EXEC_R      = 4'd4,
    S_EXEC_I      = 4'd5,
    S_ADDR        = 4'd6,
    S_MEM_RD      = 4'd7,
    S_MEM_RD_WAIT = 4'd8,
    S_WB_LD       = 4'd9,
    S_MEM_WR      = 4'd10,
    S_WB_ALU      = 4'd11,
    S_LUI         = 4'd12,
    S_BRANCH      = 4'd13,
    S_NEXT_PC     = 4'd14,
    S_HALT        = 4'd15
  } state_t;

  // Opcode values
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BEQ    = 7'b1100011;
  localparam logic [6:0] OP_BNE    = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU selector values
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_CMP = 3'b111;

  state_t r_state;
  state_t w_next;

  // ---------------------------------------------------------------------------
  // Instruction decode. These are only meaningful from DECODE onward, while
  // the IR holds the current instruction.
  // ---------------------------------------------------------------------------
  logic w_is_add;
  logic w_is_sub;
  logic w_is_rtype;
  logic w_is_addi;
  logic w_is_ld;
  logic w_is_sd;
  logic w_is_lui;
  logic w_is_beq;
  logic w_is_bne;
  logic w_is_break;
  logic w_taken;

  assign w_is_add   = (OPCODE == OP_RTYPE) && (FUNCT3 == 3'b000) &&
                      (FUNCT7 == 7'b0000000);
  assign w_is_sub   = (OPCODE == OP_RTYPE) && (FUNCT3 == 3'b000) &&
                      (FUNCT7 == 7'b0100000);
  assign w_is_rtype = w_is_add || w_is_sub;
  assign w_is_addi  = (OPCODE == OP_IMM)   && (FUNCT3 == 3'b000);
  assign w_is_ld    = (OPCODE == OP_LOAD)  && (FUNCT3 == 3'b011);
  assign w_is_sd    = (OPCODE == OP_STORE) && (FUNCT3 == 3'b111);
  assign w_is_lui   = (OPCODE == OP_LUI);
  assign w_is_beq   = (OPCODE == OP_BEQ)   && (FUNCT3 == 3'b000);
  assign w_is_bne   = (OPCODE == OP_BNE)   && (FUNCT3 == 3'b001);
  assign w_is_break = (OPCODE == OP_SYSTEM);

  // Branch outcome. BRANCH is only entered for beq or bne, so anything that
  // is not beq here is a bne.
  assign w_taken = (OPCODE == OP_BEQ) ? IGUAL : !IGUAL;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the simulator runs processes in.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  assign STATE = r_state;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic w_pc_inc;  // request the shared PC + 4 control set

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next       = r_state;
    w_pc_inc     = 1'b0;
    PC_WRITE     = 1'b0;
    IR_WRITE     = 1'b0;
    LOAD_A       = 1'b0;
    LOAD_B       = 1'b0;
    LOAD_ALUOUT  = 1'b0;
    LOAD_MDR     = 1'b0;
    BANCO_WRITE  = 1'b0;
    MEM64_WR     = 1'b0;
    PC_SRC       = 1'b0;
    ALU_SRCA     = 1'b0;
    ALU_SRCB     = 2'b00;
    ALU_SELECTOR = 3'b000;
    MEM_TO_REG   = 2'b00;
    ILLEGAL      = 1'b0;
    HALTED       = 1'b0;

    case (r_state)
      S_RESET: begin
        w_next = S_FETCH;
      end

      // Memory is addressed by PC here. The IR is loaded a cycle later,
      // once the synchronous read data is valid.
      S_FETCH: begin
        w_next = S_FETCH_WAIT;
      end

      S_FETCH_WAIT: begin
        IR_WRITE = 1'b1;
        w_next   = S_DECODE;
      end

      // Read the register file into A/B. Speculatively compute the branch
      // target PC + (imm << 1) into ALUOUT in case this is a branch.
      S_DECODE: begin
        LOAD_A       = 1'b1;
        LOAD_B       = 1'b1;
        LOAD_ALUOUT  = 1'b1;
        ALU_SRCA     = 1'b0;
        ALU_SRCB     = 2'b11;
        ALU_SELECTOR = ALU_ADD;
        if (w_is_rtype) begin
          w_next = S_EXEC_R;
        end else if (w_is_addi) begin
          w_next = S_EXEC_I;
        end else if (w_is_ld || w_is_sd) begin
          w_next = S_ADDR;
        end else if (w_is_lui) begin
          w_next = S_LUI;
        end else if (w_is_beq || w_is_bne) begin
          w_next = S_BRANCH;
        end else if (w_is_break) begin
          w_next = S_HALT;
        end else begin
          ILLEGAL = 1'b1;
          w_next  = S_NEXT_PC;
        end
      end

      S_EXEC_R: begin
        ALU_SRCA     = 1'b1;
        ALU_SRCB     = 2'b00;
        ALU_SELECTOR = w_is_sub ? ALU_SUB : ALU_ADD;
        LOAD_ALUOUT  = 1'b1;
        w_next       = S_WB_ALU;
      end

      S_EXEC_I: begin
        ALU_SRCA     = 1'b1;
        ALU_SRCB     = 2'b10;
        ALU_SELECTOR = ALU_ADD;
        LOAD_ALUOUT  = 1'b1;
        w_next       = S_WB_ALU;
      end

      // Effective address A + imm, shared by loads and stores.
      S_ADDR: begin
        ALU_SRCA     = 1'b1;
        ALU_SRCB     = 2'b10;
        ALU_SELECTOR = ALU_ADD;
        LOAD_ALUOUT  = 1'b1;
        w_next       = w_is_ld ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        w_next = S_MEM_RD_WAIT;
      end

      S_MEM_RD_WAIT: begin
        LOAD_MDR = 1'b1;
        w_next   = S_WB_LD;
      end

      S_WB_LD: begin
        BANCO_WRITE = 1'b1;
        MEM_TO_REG  = 2'b01;
        w_pc_inc    = 1'b1;
        w_next      = S_FETCH;
      end

      S_MEM_WR: begin
        MEM64_WR = 1'b1;
        w_pc_inc = 1'b1;
        w_next   = S_FETCH;
      end

      S_WB_ALU: begin
        BANCO_WRITE = 1'b1;
        MEM_TO_REG  = 2'b00;
        w_pc_inc    = 1'b1;
        w_next      = S_FETCH;
      end

      S_LUI: begin
        BANCO_WRITE = 1'b1;
        MEM_TO_REG  = 2'b10;
        w_pc_inc    = 1'b1;
        w_next      = S_FETCH;
      end

      // The ALU compares A and B. A taken branch loads the target already
      // waiting in ALUOUT. A branch that is not taken falls through to the
      // PC + 4 step.
      S_BRANCH: begin
        ALU_SRCA     = 1'b1;
        ALU_SRCB     = 2'b00;
        ALU_SELECTOR = ALU_CMP;
        if (w_taken) begin
          PC_SRC   = 1'b1;
          PC_WRITE = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next   = S_NEXT_PC;
        end
      end

      S_NEXT_PC: begin
        w_pc_inc = 1'b1;
        w_next   = S_FETCH;
      end

      // Only reset leaves HALT.
      S_HALT: begin
        HALTED = 1'b1;
        w_next = S_HALT;
      end

      default: begin
        w_next = S_RESET;
      end
    endcase

    // PC <= PC + 4. The states that request this drive no other ALU controls,
    // so applying it after the case cannot conflict.
    if (w_pc_inc) begin
      ALU_SRCA     = 1'b0;
      ALU_SRCB     = 2'b01;
      ALU_SELECTOR = ALU_ADD;
      PC_SRC       = 1'b0;
      PC_WRITE     = 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_ctrl_multiciclo
//
// Directed testbench for ctrl_multiciclo. Each task drives one group of
// instructions. At every cycle it compares STATE and the full control word
// against hand-written per-state constants.
// -----------------------------------------------------------------------------
module tb_ctrl_multiciclo;

  logic       CLK;
  logic       RESET;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic [6:0] FUNCT7;
  logic       IGUAL;
  logic       PC_WRITE, IR_WRITE, LOAD_A, LOAD_B, LOAD_ALUOUT, LOAD_MDR;
  logic       BANCO_WRITE, MEM64_WR, PC_SRC, ALU_SRCA;
  logic [1:0] ALU_SRCB;
  logic [2:0] ALU_SELECTOR;
  logic [1:0] MEM_TO_REG;
  logic       ILLEGAL, HALTED;
  logic [3:0] STATE;

  int checks = 0;
  int errors = 0;

  ctrl_multiciclo dut (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .FUNCT3(FUNCT3),
    .FUNCT7(FUNCT7), .IGUAL(IGUAL), .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE),
    .LOAD_A(LOAD_A), .LOAD_B(LOAD_B), .LOAD_ALUOUT(LOAD_ALUOUT),
    .LOAD_MDR(LOAD_MDR), .BANCO_WRITE(BANCO_WRITE), .MEM64_WR(MEM64_WR),
    .PC_SRC(PC_SRC), .ALU_SRCA(ALU_SRCA), .ALU_SRCB(ALU_SRCB),
    .ALU_SELECTOR(ALU_SELECTOR), .MEM_TO_REG(MEM_TO_REG), .ILLEGAL(ILLEGAL),
    .HALTED(HALTED), .STATE(STATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Control word layout:
  // {PCW,IRW,LA,LB,LALU,LMDR,BW,M64}_PC_SRC_SRCA_SRCB_SEL_M2R_ILL_HALT
  logic [18:0] w_ctl;
  always_comb w_ctl = {PC_WRITE, IR_WRITE, LOAD_A, LOAD_B, LOAD_ALUOUT,
                       LOAD_MDR, BANCO_WRITE, MEM64_WR, PC_SRC, ALU_SRCA,
                       ALU_SRCB, ALU_SELECTOR, MEM_TO_REG, ILLEGAL, HALTED};

  localparam logic [18:0] C_ZERO = 19'b00000000_0_0_00_000_00_0_0;
  localparam logic [18:0] C_FW   = 19'b01000000_0_0_00_000_00_0_0;
  localparam logic [18:0] C_DEC  = 19'b00111000_0_0_11_001_00_0_0;
  localparam logic [18:0] C_DILL = 19'b00111000_0_0_11_001_00_1_0;
  localparam logic [18:0] C_RADD = 19'b00001000_0_1_00_001_00_0_0;
  localparam logic [18:0] C_RSUB = 19'b00001000_0_1_00_010_00_0_0;
  localparam logic [18:0] C_IMM  = 19'b00001000_0_1_10_001_00_0_0;
  localparam logic [18:0] C_MRW  = 19'b00000100_0_0_00_000_00_0_0;
  localparam logic [18:0] C_WBA  = 19'b10000010_0_0_01_001_00_0_0;
  localparam logic [18:0] C_WBL  = 19'b10000010_0_0_01_001_01_0_0;
  localparam logic [18:0] C_LUI  = 19'b10000010_0_0_01_001_10_0_0;
  localparam logic [18:0] C_MWR  = 19'b10000001_0_0_01_001_00_0_0;
  localparam logic [18:0] C_BT   = 19'b10000000_1_1_00_111_00_0_0;
  localparam logic [18:0] C_BN   = 19'b00000000_0_1_00_111_00_0_0;
  localparam logic [18:0] C_NPC  = 19'b10000000_0_0_01_001_00_0_0;
  localparam logic [18:0] C_HALT = 19'b00000000_0_0_00_000_00_0_1;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic eq);
    OPCODE = op;
    FUNCT3 = f3;
    FUNCT7 = f7;
    IGUAL  = eq;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    checks++;
    if (STATE !== 4'd0 || w_ctl !== C_ZERO) begin
      errors++;
      $display("FAIL reset_state: STATE=%0d ctl=%b, want 0 / %b", STATE, w_ctl, C_ZERO);
    end
    tick();
    checks++;
    if (STATE !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: STATE=%0d, want 0", STATE);
    end
    #2 RESET = 1'b1;
    tick();
    checks++;
    if (STATE !== 4'd1 || w_ctl !== C_ZERO) begin
      errors++;
      $display("FAIL reset_to_fetch: STATE=%0d ctl=%b, want 1 / %b", STATE, w_ctl, C_ZERO);
    end
  endtask

  // ---------------------------------------------------------------------------
  // add, sub, addi, lui
  task automatic test_alu();
    string        name;
    logic [27:0]  seq;
    logic [132:0] ctls;
    int           n;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin
          name = "add"; set_ir(7'b0110011, 3'b000, 7'b0000000, 1'b0);
          seq = 28'h1234B00; n = 5;
          ctls = {C_ZERO, C_FW, C_DEC, C_RADD, C_WBA, C_ZERO, C_ZERO};
        end
        1: begin
          name = "sub"; set_ir(7'b0110011, 3'b000, 7'b0100000, 1'b1);
          seq = 28'h1234B00; n = 5;
          ctls = {C_ZERO, C_FW, C_DEC, C_RSUB, C_WBA, C_ZERO, C_ZERO};
        end
        2: begin
          name = "addi"; set_ir(7'b0010011, 3'b000, 7'b1111111, 1'b0);
          seq = 28'h1235B00; n = 5;
          ctls = {C_ZERO, C_FW, C_DEC, C_IMM, C_WBA, C_ZERO, C_ZERO};
        end
        default: begin
          name = "lui"; set_ir(7'b0110111, 3'b101, 7'b0000000, 1'b0);
          seq = 28'h123C000; n = 4;
          ctls = {C_ZERO, C_FW, C_DEC, C_LUI, C_ZERO, C_ZERO, C_ZERO};
        end
      endcase
      for (int i = 0; i < n; i++) begin
        checks++;
        if (STATE !== seq[(6-i)*4 +: 4]) begin
          errors++;
          $display("FAIL %s cycle %0d: STATE=%0d want %0d", name, i, STATE, seq[(6-i)*4 +: 4]);
        end
        checks++;
        if (w_ctl !== ctls[(6-i)*19 +: 19]) begin
          errors++;
          $display("FAIL %s cycle %0d: ctl=%b want %b", name, i, w_ctl, ctls[(6-i)*19 +: 19]);
        end
        tick();
      end
      checks++;
      if (STATE !== 4'd1) begin
        errors++;
        $display("FAIL %s end: STATE=%0d want 1", name, STATE);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // ld and sd
  task automatic test_mem();
    string        name;
    logic [27:0]  seq;
    logic [132:0] ctls;
    int           n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        name = "ld"; set_ir(7'b0000011, 3'b011, 7'b0000000, 1'b0);
        seq = 28'h1236789; n = 7;
        ctls = {C_ZERO, C_FW, C_DEC, C_IMM, C_ZERO, C_MRW, C_WBL};
      end else begin
        name = "sd"; set_ir(7'b0100011, 3'b111, 7'b0000000, 1'b1);
        seq = 28'h1236A00; n = 5;
        ctls = {C_ZERO, C_FW, C_DEC, C_IMM, C_MWR, C_ZERO, C_ZERO};
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (STATE !== seq[(6-i)*4 +: 4]) begin
          errors++;
          $display("FAIL %s cycle %0d: STATE=%0d want %0d", name, i, STATE, seq[(6-i)*4 +: 4]);
        end
        checks++;
        if (w_ctl !== ctls[(6-i)*19 +: 19]) begin
          errors++;
          $display("FAIL %s cycle %0d: ctl=%b want %b", name, i, w_ctl, ctls[(6-i)*19 +: 19]);
        end
        tick();
      end
      checks++;
      if (STATE !== 4'd1) begin
        errors++;
        $display("FAIL %s end: STATE=%0d want 1", name, STATE);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // beq and bne, both taken and not taken
  task automatic test_branch();
    string        name;
    logic [27:0]  seq;
    logic [132:0] ctls;
    int           n;
    logic         taken;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin name = "beq_eq";  set_ir(7'b1100011, 3'b000, 7'b0, 1'b1); taken = 1'b1; end
        1: begin name = "beq_ne";  set_ir(7'b1100011, 3'b000, 7'b0, 1'b0); taken = 1'b0; end
        2: begin name = "bne_eq";  set_ir(7'b1100111, 3'b001, 7'b0, 1'b1); taken = 1'b0; end
        default: begin name = "bne_ne"; set_ir(7'b1100111, 3'b001, 7'b0, 1'b0); taken = 1'b1; end
      endcase
      if (taken) begin
        seq = 28'h123D000; n = 4;
        ctls = {C_ZERO, C_FW, C_DEC, C_BT, C_ZERO, C_ZERO, C_ZERO};
      end else begin
        seq = 28'h123DE00; n = 5;
        ctls = {C_ZERO, C_FW, C_DEC, C_BN, C_NPC, C_ZERO, C_ZERO};
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (STATE !== seq[(6-i)*4 +: 4]) begin
          errors++;
          $display("FAIL %s cycle %0d: STATE=%0d want %0d", name, i, STATE, seq[(6-i)*4 +: 4]);
        end
        checks++;
        if (w_ctl !== ctls[(6-i)*19 +: 19]) begin
          errors++;
          $display("FAIL %s cycle %0d: ctl=%b want %b", name, i, w_ctl, ctls[(6-i)*19 +: 19]);
        end
        tick();
      end
      checks++;
      if (STATE !== 4'd1) begin
        errors++;
        $display("FAIL %s end: STATE=%0d want 1", name, STATE);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Unsupported encodings: unknown opcode, bad R-type funct7, wrong ld funct3
  task automatic test_illegal();
    string        name;
    logic [27:0]  seq;
    logic [132:0] ctls;
    seq  = 28'h123E000;
    ctls = {C_ZERO, C_FW, C_DILL, C_NPC, C_ZERO, C_ZERO, C_ZERO};
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin name = "ill_op7f"; set_ir(7'b1111111, 3'b000, 7'b0000000, 1'b0); end
        1: begin name = "ill_f7";   set_ir(7'b0110011, 3'b000, 7'b0000001, 1'b0); end
        default: begin name = "ill_ldf3"; set_ir(7'b0000011, 3'b010, 7'b0000000, 1'b0); end
      endcase
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (STATE !== seq[(6-i)*4 +: 4]) begin
          errors++;
          $display("FAIL %s cycle %0d: STATE=%0d want %0d", name, i, STATE, seq[(6-i)*4 +: 4]);
        end
        checks++;
        if (w_ctl !== ctls[(6-i)*19 +: 19]) begin
          errors++;
          $display("FAIL %s cycle %0d: ctl=%b want %b", name, i, w_ctl, ctls[(6-i)*19 +: 19]);
        end
        tick();
      end
      checks++;
      if (STATE !== 4'd1) begin
        errors++;
        $display("FAIL %s end: STATE=%0d want 1", name, STATE);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Asynchronous reset while a load sits in MEM_RD_WAIT
  task automatic test_reset_midflight();
    set_ir(7'b0000011, 3'b011, 7'b0000000, 1'b0);
    repeat (5) tick();
    checks++;
    if (STATE !== 4'd8 || LOAD_MDR !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach_mrw: STATE=%0d LOAD_MDR=%b, want 8 / 1", STATE, LOAD_MDR);
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (STATE !== 4'd0 || w_ctl !== C_ZERO) begin
      errors++;
      $display("FAIL mid_async_reset: STATE=%0d ctl=%b, want 0 / %b", STATE, w_ctl, C_ZERO);
    end
    #2 RESET = 1'b1;
    tick();
    checks++;
    if (STATE !== 4'd1) begin
      errors++;
      $display("FAIL mid_release: STATE=%0d want 1", STATE);
    end
  endtask

  // ---------------------------------------------------------------------------
  // break: three cycles to HALT, then hold, then reset out of HALT
  task automatic test_break();
    set_ir(7'b1110011, 3'b000, 7'b0000000, 1'b0);
    checks++;
    if (STATE !== 4'd1) begin
      errors++;
      $display("FAIL break_c0: STATE=%0d want 1", STATE);
    end
    tick();
    checks++;
    if (STATE !== 4'd2 || w_ctl !== C_FW) begin
      errors++;
      $display("FAIL break_c1: STATE=%0d ctl=%b want 2 / %b", STATE, w_ctl, C_FW);
    end
    tick();
    checks++;
    if (STATE !== 4'd3 || w_ctl !== C_DEC) begin
      errors++;
      $display("FAIL break_c2: STATE=%0d ctl=%b want 3 / %b", STATE, w_ctl, C_DEC);
    end
    tick();
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (STATE !== 4'd15 || w_ctl !== C_HALT) begin
        errors++;
        $display("FAIL halt_hold %0d: STATE=%0d ctl=%b want 15 / %b", i, STATE, w_ctl, C_HALT);
      end
      IGUAL = ~IGUAL;
      tick();
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if (STATE !== 4'd0 || HALTED !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: STATE=%0d HALTED=%b want 0 / 0", STATE, HALTED);
    end
    #2 RESET = 1'b1;
    tick();
    checks++;
    if (STATE !== 4'd1) begin
      errors++;
      $display("FAIL halt_release: STATE=%0d want 1", STATE);
    end
  endtask

  initial begin
    RESET = 1'b0;
    set_ir(7'b0, 3'b0, 7'b0, 1'b0);
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_midflight();
    test_break();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
